// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 init states, instruction bytes and datasheet delays shared by the init sequencer and the refresh driver
package lcd_pkg;
    typedef enum logic [2:0] {
        INIT_POWER_WAIT,
        INIT_SETUP,
        INIT_E_HIGH,
        INIT_HOLD,
        INIT_DELAY,
        INIT_DONE
    } init_state_t;
    localparam logic [7:0] CMD_FUNC_SET_8BIT = 8'h30;
    localparam logic [7:0] CMD_FSET_TWO_LINE = 8'h08;
    localparam logic [7:0] CMD_DISPLAY_OFF   = 8'h08;
    localparam logic [7:0] CMD_CLEAR         = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC     = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'h0C;
    localparam logic [15:0] DLY_WAKE1_US = 16'd4100;
    localparam logic [15:0] DLY_WAKE_US  = 16'd100;
    localparam logic [15:0] DLY_CMD_US   = 16'd40;
    localparam logic [15:0] DLY_CLEAR_US = 16'd1640;
    localparam logic [2:0]  LAST_STEP    = 3'd7;
    function automatic logic [7:0] func_set(input logic two_line);
        return CMD_FUNC_SET_8BIT | (two_line ? CMD_FSET_TWO_LINE : 8'h00);
    endfunction
endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: reset-by-instruction step table, step -> {instruction byte, post-write delay in us}
import lcd_pkg::*;
module lcd_init_rom #(
    parameter bit TWO_LINE = 1'b1
) (
    input  logic [2:0]  i_step,
    output logic [7:0]  o_byte,
    output logic [15:0] o_delay_us
);
    always_comb begin
        o_byte     = CMD_DISPLAY_ON;
        o_delay_us = DLY_CMD_US;
        case (i_step)
            3'd0: begin o_byte = CMD_FUNC_SET_8BIT;  o_delay_us = DLY_WAKE1_US; end
            3'd1: begin o_byte = CMD_FUNC_SET_8BIT;  o_delay_us = DLY_WAKE_US;  end
            3'd2: begin o_byte = CMD_FUNC_SET_8BIT;  o_delay_us = DLY_WAKE_US;  end
            3'd3: begin o_byte = func_set(TWO_LINE); o_delay_us = DLY_CMD_US;   end
            3'd4: begin o_byte = CMD_DISPLAY_OFF;    o_delay_us = DLY_CMD_US;   end
            3'd5: begin o_byte = CMD_CLEAR;          o_delay_us = DLY_CLEAR_US; end
            3'd6: begin o_byte = CMD_ENTRY_INC;      o_delay_us = DLY_CMD_US;   end
            default: ;
        endcase
    end
endmodule

// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: timed HD44780 8-bit power-on init; owns the LCD bus until o_initilized rises
import lcd_pkg::*;
module lcd_init_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int POWERUP_US = 40_000,
    parameter int SETUP_CYC  = 2,
    parameter int E_CYC      = 13,
    parameter bit TWO_LINE   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_reinit,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data_out,
    output logic       o_lcd_data_oe,
    output logic       o_initilized
);
    localparam logic [31:0] CYC_PER_US = 32'(CLK_HZ / 1_000_000);
    localparam logic [31:0] POWER_CYC  = 32'(POWERUP_US) * CYC_PER_US;
    init_state_t r_state, w_next;
    logic [2:0]  r_step, w_step_next;
    logic [31:0] r_cnt, r_dly_cyc, w_len;
    logic        w_last, r_e, r_oe, r_init;
    logic [7:0]  r_data, w_byte;
    logic [15:0] w_delay_us;
    lcd_init_rom #(.TWO_LINE(TWO_LINE)) u_rom (
        .i_step     (w_step_next),
        .o_byte     (w_byte),
        .o_delay_us (w_delay_us)
    );
    always_comb begin
        w_len  = r_state == INIT_POWER_WAIT ? POWER_CYC :
                 r_state == INIT_SETUP      ? 32'(SETUP_CYC) :
                 r_state == INIT_E_HIGH     ? 32'(E_CYC) :
                 r_state == INIT_DELAY      ? r_dly_cyc : 32'd1;
        w_last = r_cnt == w_len - 32'd1;
    end
    always_comb begin
        w_next      = r_state;
        w_step_next = r_step;
        case (r_state)
            INIT_POWER_WAIT: if (w_last) begin w_next = INIT_SETUP; w_step_next = 3'd0; end
            INIT_SETUP:      if (w_last) w_next = INIT_E_HIGH;
            INIT_E_HIGH:     if (w_last) w_next = INIT_HOLD;
            INIT_HOLD:       w_next = INIT_DELAY;
            INIT_DELAY: begin
                if (w_last) begin
                    w_next      = r_step == LAST_STEP ? INIT_DONE : INIT_SETUP;
                    w_step_next = r_step == LAST_STEP ? r_step : r_step + 3'd1;
                end
            end
            INIT_DONE:       if (i_reinit) begin w_next = INIT_SETUP; w_step_next = 3'd0; end
            default:         w_next = INIT_POWER_WAIT;
        endcase
    end
    // outputs are registered from the next state so they line up with r_state and E cannot glitch
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= INIT_POWER_WAIT;
            r_step    <= 3'd0;
            r_cnt     <= '0;
            r_dly_cyc <= '0;
            r_e       <= 1'b0;
            r_oe      <= 1'b0;
            r_init    <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_state <= w_next;
            r_step  <= w_step_next;
            r_cnt   <= (w_next != r_state || r_state == INIT_DONE) ? '0 : r_cnt + 32'd1;
            r_e     <= w_next == INIT_E_HIGH;
            r_oe    <= w_next inside {INIT_SETUP, INIT_E_HIGH, INIT_HOLD};
            r_init  <= w_next == INIT_DONE;
            if (w_next == INIT_SETUP && r_state != INIT_SETUP) begin
                r_data    <= w_byte;
                r_dly_cyc <= 32'(w_delay_us) * CYC_PER_US;
            end
        end
    end
    assign o_lcd_rs       = 1'b0;
    assign o_lcd_rw       = 1'b0;
    assign o_lcd_e        = r_e;
    assign o_lcd_data_out = r_data;
    assign o_lcd_data_oe  = r_oe;
    assign o_initilized   = r_init;
endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb_lcd_init_sequencer: checks the init bus waveform against a pulse schedule built from the step table
module tb_lcd_init_sequencer;
    localparam int CYC = 1;
    localparam int E   = 3;
    logic clk = 1'b0, reset_n = 1'b0, reinit = 1'b0;
    logic rs, rw, e, oe, init;
    logic [7:0] data;
    int n_cmp = 0, n_bad = 0, edge_n = 0;
    logic [7:0] exp_byte [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    int exp_dly [8] = '{4100, 100, 100, 40, 40, 1640, 40, 40};
    always #5 clk = ~clk;
    lcd_init_sequencer #(
        .CLK_HZ(1_000_000), .POWERUP_US(50), .SETUP_CYC(2), .E_CYC(E), .TWO_LINE(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_reinit(reinit),
        .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_e(e),
        .o_lcd_data_out(data), .o_lcd_data_oe(oe), .o_initilized(init)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask
    // Expected schedule: E rises 2 cycles after OE, stays E cycles, then 1 hold + delay + 2 setup to the next rise.
    task automatic run_seq(input int oe_edge, input int abort_step, input int hold, input bit noise);
        int rise [8];
        int done_edge, stop, nf;
        int obs_rise [$];
        bit pe;
        logic ee, eoe;
        rise[0] = oe_edge + 2;
        for (int k = 1; k < 8; k++) rise[k] = rise[k-1] + E + 1 + exp_dly[k-1] * CYC + 2;
        done_edge = rise[7] + E + 1 + exp_dly[7] * CYC;
        stop = abort_step >= 0 ? rise[abort_step] + 1 : done_edge + hold;
        nf = 0;
        pe = 1'b0;
        forever begin
            ee = 1'b0;
            eoe = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (edge_n >= rise[k] && edge_n < rise[k] + E) ee = 1'b1;
                if (edge_n >= rise[k] - 2 && edge_n <= rise[k] + E) eoe = 1'b1;
            end
            chk("bus{e,oe,init,rs,rw}", {27'd0, e, oe, init, rs, rw},
                {27'd0, ee, eoe, edge_n >= done_edge, 2'b00});
            if (e && !pe) obs_rise.push_back(edge_n);
            if (!e && pe) begin
                if (nf < 8) chk("byte_at_e_fall", {24'd0, data}, {24'd0, exp_byte[nf]});
                else chk("pulse_count", nf + 1, 8);
                nf++;
            end
            pe = e;
            if (edge_n >= stop) break;
            reinit = noise && !reinit && edge_n < done_edge &&
                     ($urandom_range(0, 99) == 0 || (ee && $urandom_range(0, 2) == 0));
            tick();
        end
        reinit = 1'b0;
        if (abort_step < 0) begin
            chk("pulses", obs_rise.size(), 8);
            if (obs_rise.size() == 8) begin
                chk("first_rise_after_oe", obs_rise[0] - oe_edge, 2);
                chk("gap_step0_1", obs_rise[1] - (obs_rise[0] + E), 1 + 4100 + 2);
                chk("gap_step5_6", obs_rise[6] - (obs_rise[5] + E), 1 + 1640 + 2);
            end
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", {27'd0, e, oe, init, rs, rw}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        #2 reset_n = 1'b1;
        edge_n = 0;
        run_seq(50, -1, 10_000, 1'b1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        run_seq(edge_n, -1, int'($urandom_range(50, 500)), 1'b1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        run_seq(edge_n, 3, 0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_bus", {27'd0, e, oe, init, rs, rw}, 32'd0);
        chk("async_reset_data", {24'd0, data}, 32'd0);
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b1;
        edge_n = 0;
        run_seq(50, -1, 100, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
